video_capture: RTL and testbench

//  Receive-side counterpart of the HDMI video transmitter. Samples a parallel HDMI pixel bus and its

---
 rtl/video_capture.sv | 214 +++++++++++++++++++++
 tb/tb_video_capture.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_capture.sv
`timescale 1ns/1ps
// video_capture
//   Receive side of the parallel HDMI video link. The pixel clock and all
//   video inputs are oversampled on clk; on each detected pixel-clock rising
//   edge the frame-lock FSM advances and, while capturing, active pixels are
//   packed to RGB888 and pushed into a small first-word-fall-through FIFO
//   tagged with start-of-frame and end-of-line.
//
//   Optional build macro: VIDEO_CAPTURE_TIMING_CHECK_EN adds the short-line /
//   wrong-line-count detector behind timing_err. Without it timing_err is 0.
//
// Ports
//   clk, rst                 system clock, async active-high reset
//   HDMI_CLK                 pixel clock (<= clk/4), treated as data
//   HDMI_DATA[35:0]          {R[11:0],G[11:0],B[11:0]}, top 8 bits per channel used
//   HDMI_HSYNC, HDMI_VSYNC   active-low syncs (hsync is not needed for capture)
//   HDMI_EN                  data enable
//   pix_data/sof/eol/valid   FIFO head, valid = FIFO non-empty
//   pix_ready                downstream accept
//   locked                   capturing a frame in sync
//   overflow                 sticky, pixel dropped on full FIFO
//   clr_status               clears overflow and timing_err (a new set wins)
//   timing_err               sticky timing violation (macro build only)
//
// state     | meaning
// S_SEEK    | lost or never had sync; wait for vsync low
// S_SYNC    | inside vsync; wait for vsync high to start a frame
// S_CAPTURE | pushing active pixels of the current frame
module video_capture #(
   parameter int H_ACTIVE   = 720,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        HDMI_CLK,
   input  logic [35:0] HDMI_DATA,
   input  logic        HDMI_HSYNC,
   input  logic        HDMI_VSYNC,
   input  logic        HDMI_EN,
   output logic [23:0] pix_data,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        locked,
   output logic        overflow,
   input  logic        clr_status,
   output logic        timing_err
);

   localparam int HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int VW = $clog2(V_ACTIVE + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_SEEK, S_SYNC, S_CAPTURE} state_t;

   // input synchronisers; video signals get two flops so they line up with clk_s2
   logic        clk_s1, clk_s2, clk_s3;
   logic [23:0] pix_d1, pix_d2;
   logic        vs_d1, vs_d2, en_d1, en_d2;
   logic        rise;

   logic unused_inputs;
   assign unused_inputs = ^{HDMI_HSYNC, HDMI_DATA[27:24], HDMI_DATA[15:12], HDMI_DATA[3:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1 <= 1'b0;
         clk_s2 <= 1'b0;
         clk_s3 <= 1'b0;
         pix_d1 <= '0;
         pix_d2 <= '0;
         vs_d1  <= 1'b0;
         vs_d2  <= 1'b0;
         en_d1  <= 1'b0;
         en_d2  <= 1'b0;
      end else begin
         clk_s1 <= HDMI_CLK;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         pix_d1 <= {HDMI_DATA[35:28], HDMI_DATA[23:16], HDMI_DATA[11:4]};
         pix_d2 <= pix_d1;
         vs_d1  <= HDMI_VSYNC;
         vs_d2  <= vs_d1;
         en_d1  <= HDMI_EN;
         en_d2  <= en_d1;
      end
   end

   assign rise = clk_s2 & ~clk_s3;

   // FIFO: entry = {pixel, sof, eol}
   logic [25:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_count;
   logic          full, pop, want_push, push, drop;

   state_t        state;
   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic          sof_pend, first_entry, frame_ok;

   assign pix_valid = (fifo_count != '0);
   assign full      = (fifo_count == CW'(FIFO_DEPTH));
   assign pop       = pix_valid & pix_ready;
   assign want_push = rise & (state == S_CAPTURE) & en_d2;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push      = want_push & (~full | pop);
   assign drop      = want_push & full & ~pop;

   assign pix_data = mem[rd_ptr][25:2];
   assign pix_sof  = mem[rd_ptr][1];
   assign pix_eol  = mem[rd_ptr][0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {pix_d2, sof_pend, hcount == HW'(H_ACTIVE - 1)};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

`ifdef VIDEO_CAPTURE_TIMING_CHECK_EN
   logic en_prev;
   logic terr_set;
   assign terr_set = rise & (state == S_CAPTURE) &
                     ((en_prev & ~en_d2 & (hcount != '0)) |
                      (~vs_d2 & (vcount != VW'(V_ACTIVE))));
`else
   assign timing_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_SEEK;
         hcount      <= '0;
         vcount      <= '0;
         sof_pend    <= 1'b0;
         first_entry <= 1'b1;
         frame_ok    <= 1'b0;
         locked      <= 1'b0;
         overflow    <= 1'b0;
`ifdef VIDEO_CAPTURE_TIMING_CHECK_EN
         en_prev     <= 1'b0;
         timing_err  <= 1'b0;
`endif
      end else begin
         if (drop)            overflow <= 1'b1;
         else if (clr_status) overflow <= 1'b0;

`ifdef VIDEO_CAPTURE_TIMING_CHECK_EN
         if (terr_set)        timing_err <= 1'b1;
         else if (clr_status) timing_err <= 1'b0;
         if (rise) en_prev <= en_d2;
`endif

         if (rise) begin
            case (state)
               S_SEEK: begin
                  if (!vs_d2) state <= S_SYNC;
               end
               S_SYNC: begin
                  if (vs_d2) begin
                     state       <= S_CAPTURE;
                     hcount      <= '0;
                     vcount      <= '0;
                     sof_pend    <= 1'b1;
                     locked      <= first_entry | frame_ok;
                     first_entry <= 1'b0;
                  end
               end
               S_CAPTURE: begin
                  if (drop) begin
                     // abandon the frame; buffered pixels still drain
                     state       <= S_SEEK;
                     locked      <= 1'b0;
                     first_entry <= 1'b1;
                  end else begin
                     if (push) begin
                        sof_pend <= 1'b0;
                        if (hcount == HW'(H_ACTIVE - 1)) begin
                           hcount <= '0;
                           vcount <= vcount + VW'(1);
                        end else begin
                           hcount <= hcount + HW'(1);
                        end
                     end
                     if (!vs_d2) begin
                        state    <= S_SYNC;
                        frame_ok <= (vcount == VW'(V_ACTIVE));
                     end
                  end
               end
               default: state <= S_SEEK;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_video_capture.sv
`timescale 1ns/1ps
module tb_video_capture;
   localparam int H = 8;
   localparam int V = 4;
   localparam int D = 8;
   localparam int M_FLOW = 0, M_STALL = 1, M_PULSE = 2, M_RAND = 3;
`ifdef VIDEO_CAPTURE_TIMING_CHECK_EN
   localparam bit TCHK = 1'b1;
`else
   localparam bit TCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        HDMI_CLK, HDMI_HSYNC, HDMI_VSYNC, HDMI_EN;
   logic [35:0] HDMI_DATA;
   logic [23:0] pix_data;
   logic        pix_sof, pix_eol, pix_valid, pix_ready;
   logic        locked, overflow, clr_status, timing_err;

   always #5 clk = ~clk;

   video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .HDMI_CLK(HDMI_CLK), .HDMI_DATA(HDMI_DATA), .HDMI_HSYNC(HDMI_HSYNC),
      .HDMI_VSYNC(HDMI_VSYNC), .HDMI_EN(HDMI_EN),
      .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .locked(locked), .overflow(overflow), .clr_status(clr_status),
      .timing_err(timing_err));

   int vectors = 0;
   int miscompares = 0;
   logic [25:0] exp_q[$];

   int  mode = M_FLOW;
   bit  pulse_on = 0, clr_on = 0, collide = 0;
   bit  model_first = 1, dropped = 0, exp_ovf = 0;
   int  frame_pix = 0, buffered = 0, prev_pixels = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitor: any transfer must match the head of the expected queue
   initial begin
      logic [25:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (rst === 1'b0 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_pixel: got %h expected none", {pix_data, pix_sof, pix_eol});
            end else begin
               e = exp_q.pop_front();
               check("pixel", {6'd0, pix_data, pix_sof, pix_eol}, {6'd0, e});
            end
         end
      end
   end

   task automatic tick(input bit slot);
      @(negedge clk);
      case (mode)
         M_FLOW:  pix_ready = 1'b1;
         M_STALL: pix_ready = 1'b0;
         M_PULSE: pix_ready = slot & pulse_on;
         default: pix_ready = ($urandom_range(0, 3) != 0);
      endcase
      clr_status = slot & clr_on;
   endtask

   // one pixel-clock period (8 clk); slot 1 is the cycle the DUT sees the rise
   task automatic pclk(input bit en, input bit vs, input bit hs, input logic [35:0] d);
      HDMI_DATA  = d;
      HDMI_EN    = en;
      HDMI_VSYNC = vs;
      HDMI_HSYNC = hs;
      HDMI_CLK   = 1'b0;
      repeat (4) tick(0);
      HDMI_CLK = 1'b1;
      tick(0);
      tick(1);
      tick(0);
      tick(0);
   endtask

   task automatic frame_start();
      bit exp_lock;
      repeat (2) pclk(0, 0, 1, 36'h0);
      repeat (2) pclk(0, 1, 1, 36'h0);
      exp_lock = model_first || ((prev_pixels / H) == V);
      check("locked_frame_start", locked, exp_lock);
      model_first = 0;
      frame_pix = 0;
      buffered = 0;
      dropped = 0;
   endtask

   task automatic send_pixel();
      logic [35:0] d;
      logic [23:0] p;
      d = {$urandom, $urandom_range(0, 15)};
      p = {d[35:28], d[23:16], d[11:4]};
      if (!dropped) begin
         if (mode == M_STALL && buffered >= D) begin
            dropped = 1;
            exp_ovf = 1;
            model_first = 1;
            clr_on = collide;
         end else begin
            exp_q.push_back({p, frame_pix == 0, (frame_pix % H) == H - 1});
            buffered++;
            frame_pix++;
            pulse_on = (mode == M_PULSE) && (buffered > D);
         end
      end
      pclk(1, 1, 1, d);
      pulse_on = 0;
      clr_on = 0;
   endtask

   task automatic send_frame(input int nlines, input int short_line);
      frame_start();
      for (int l = 0; l < nlines; l++) begin
         repeat (2) pclk(0, 1, 0, 36'h0);
         pclk(0, 1, 1, 36'h0);
         for (int p = 0; p < ((l == short_line) ? H - 1 : H); p++) send_pixel();
      end
      repeat (2) pclk(0, 1, 1, 36'h0);
      prev_pixels = dropped ? 0 : frame_pix;
   endtask

   task automatic drain();
      int n;
      mode = M_FLOW;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         tick(0);
         n++;
      end
      repeat (3) tick(0);
      check("pixels_outstanding", exp_q.size(), 0);
      check("fifo_empty", pix_valid, 0);
   endtask

   task automatic clear_status();
      clr_on = 1;
      tick(1);
      clr_on = 0;
      tick(0);
      exp_ovf = 0;
   endtask

   initial begin
      rst = 1'b1;
      HDMI_CLK = 1'b0;
      HDMI_DATA = '0;
      HDMI_HSYNC = 1'b1;
      HDMI_VSYNC = 1'b1;
      HDMI_EN = 1'b0;
      pix_ready = 1'b0;
      clr_status = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", pix_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_overflow", overflow, 0);
      check("rst_timing_err", timing_err, 0);
      check("rst_data", {pix_data, pix_sof, pix_eol}, 0);
      rst = 1'b0;

      // nominal and random-ready capture
      mode = M_FLOW;
      repeat (2) send_frame(V, -1);
      check("overflow_nominal", overflow, 0);
      mode = M_RAND;
      repeat (2) send_frame(V, -1);
      drain();
      check("overflow_random", overflow, exp_ovf);

      // backpressure: 8 buffered, 9th dropped, rest of frame discarded
      mode = M_STALL;
      collide = 0;
      send_frame(V, -1);
      check("overflow_drop", overflow, exp_ovf);
      check("locked_drop", locked, 0);
      check("valid_held", pix_valid, 1);
      drain();
      clear_status();
      check("overflow_clr", overflow, exp_ovf);

      // full FIFO with pop on the push cycle: no drop
      mode = M_PULSE;
      send_frame(V, -1);
      check("overflow_pulse", overflow, exp_ovf);
      drain();

      // clr_status colliding with a drop: set wins
      mode = M_STALL;
      collide = 1;
      send_frame(V, -1);
      collide = 0;
      check("overflow_collide", overflow, 1);
      drain();
      clear_status();
      check("overflow_clr2", overflow, 0);

      // timing violations: short line, then short frame
      mode = M_FLOW;
      send_frame(V, -1);
      check("terr_clean", timing_err, 0);
      send_frame(V, 1);
      send_frame(V, -1);
      check("terr_short_line", timing_err, TCHK);
      clear_status();
      check("terr_clr", timing_err, 0);
      send_frame(V - 1, -1);
      send_frame(V, -1);
      check("terr_short_frame", timing_err, TCHK);
      clear_status();
      drain();

      // reset in the middle of a captured frame
      mode = M_STALL;
      frame_start();
      repeat (3) send_pixel();
      check("valid_before_rst", pix_valid, 1);
      rst = 1'b1;
      #1;
      check("midrst_valid", pix_valid, 0);
      check("midrst_locked", locked, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_data", {pix_data, pix_sof, pix_eol}, 0);
      exp_q.delete();
      model_first = 1;
      exp_ovf = 0;
      tick(0);
      tick(0);
      rst = 1'b0;
      mode = M_FLOW;
      send_frame(V, -1);
      drain();
      check("overflow_final", overflow, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
